stg_ma: RTL and testbench

- Pipeline stage 5 (memory access), sitting between the execute stage and stg_wb.
- Issues loads and stores to data memory over a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Registers the instruction bundle, plus load data when it arrives, into the signals consumed by writeback.

---
 rtl/stg_ma_pkg.sv | 34 +++
 rtl/stg_ma_if.sv | 32 +++
 rtl/stg_ma_memif.sv | 115 +++++++++++
 rtl/stg_ma.sv | 151 +++++++++++++++
 tb/tb_stg_ma.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stg_ma_pkg.sv
// Shared sizes, state encodings and helpers for the memory-access stage.
// Optional feature macro used by this block: AMBER_MA_TIMEOUT_EN.
package stg_ma_pkg;

  // Field widths of the instruction bundle.
  localparam int unsigned SIZE_DATA   = 24;
  localparam int unsigned SIZE_ADDR   = 48;
  localparam int unsigned SIZE_OPC    = 8;
  localparam int unsigned SIZE_TGT_GP = 4;
  localparam int unsigned SIZE_TGT_SR = 2;
  localparam int unsigned SIZE_TGT_AR = 2;

  // Memory-access state machine.
  localparam int unsigned SIZE_MA_STATE = 2;
  localparam int unsigned HBIT_MA_STATE = SIZE_MA_STATE - 1;
  localparam int unsigned SIZE_MA_TMO   = 8;

  localparam logic [HBIT_MA_STATE:0] MA_S_IDLE  = 2'd0;
  localparam logic [HBIT_MA_STATE:0] MA_S_WAIT  = 2'd1;
  localparam logic [HBIT_MA_STATE:0] MA_S_ABORT = 2'd2;

  // StAbort is reserved; the FSM never enters it.
  typedef enum logic [HBIT_MA_STATE:0] {
    StIdle  = MA_S_IDLE,
    StWait  = MA_S_WAIT,
    StAbort = MA_S_ABORT
  } ma_state_e;

  // A store wins when both flags are set, so any flag starts an access.
  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/stg_ma_if.sv
// Data-memory request/acknowledge bus between stg_ma and the memory.
interface stg_ma_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 48
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );

endinterface

// File: rtl/stg_ma_memif.sv
// Memory-access control: state machine, request registers, optional timeout
// and stall/error decode. Timeout logic exists only with AMBER_MA_TIMEOUT_EN.
module stg_ma_memif
  import stg_ma_pkg::*;
#(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned ADDR_W      = 48,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              start,
  input  logic              start_we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_wdata,
  input  logic              ack,
  output logic              req,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              done,
  output logic              expire,
  output logic              err
);

  ma_state_e         state_q, state_d;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              tmo_hit;

  // State register.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state plus completion/expiry strobes; an ack beats a timeout.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    expire  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StWait;
      end
      StWait: begin
        if (ack) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (tmo_hit) begin
          expire  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request registers: loaded on issue, held through the wait, req dropped on exit.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == StIdle && start) begin
      req_q   <= 1'b1;
      we_q    <= start_we;
      addr_q  <= start_addr;
      wdata_q <= start_wdata;
    end else if (done || expire) begin
      req_q   <= 1'b0;
    end
  end

  assign req   = req_q;
  assign we    = we_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign stall = (state_q != StIdle);

`ifdef AMBER_MA_TIMEOUT_EN
  // Expire in the TIMEOUT_CYC-th cycle of the wait.
  localparam logic [SIZE_MA_TMO-1:0] TmoLast = SIZE_MA_TMO'(TIMEOUT_CYC - 1);

  logic [SIZE_MA_TMO-1:0] tmo_cnt_q;
  logic                   err_q;

  // Wait-cycle counter, cleared whenever not waiting (so on entry to the wait).
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst)                 tmo_cnt_q <= '0;
    else if (state_q != StWait) tmo_cnt_q <= '0;
    else                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign tmo_hit = (state_q == StWait) && (tmo_cnt_q == TmoLast);

  // One-cycle error pulse following an expiry.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) err_q <= 1'b0;
    else        err_q <= expire;
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign tmo_hit        = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: rtl/stg_ma.sv
// Pipeline stage 5 (memory access): passes the bundle to writeback, issuing
// loads/stores over stg_ma_if and stalling upstream while one is outstanding.
// Optional timeout abort is enabled by AMBER_MA_TIMEOUT_EN.
module stg_ma
  import stg_ma_pkg::*;
#(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned ADDR_W      = 48,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic [ADDR_W-1:0]      iw_pc,
  input  logic [DATA_W-1:0]      iw_instr,
  input  logic [SIZE_OPC-1:0]    iw_opc,
  input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
  input  logic                   iw_tgt_gp_we,
  input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
  input  logic                   iw_tgt_sr_we,
  input  logic [SIZE_TGT_AR-1:0] iw_tgt_ar,
  input  logic                   iw_tgt_ar_we,
  input  logic [DATA_W-1:0]      iw_result,
  input  logic [ADDR_W-1:0]      iw_sr_result,
  input  logic [ADDR_W-1:0]      iw_ar_result,
  input  logic                   iw_mem_rd,
  input  logic                   iw_mem_wr,
  input  logic [ADDR_W-1:0]      iw_mem_addr,
  input  logic [DATA_W-1:0]      iw_mem_wdata,
  stg_ma_if.master               mem,
  output logic [ADDR_W-1:0]      ow_pc,
  output logic [DATA_W-1:0]      ow_instr,
  output logic [SIZE_OPC-1:0]    ow_opc,
  output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
  output logic                   ow_tgt_gp_we,
  output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
  output logic                   ow_tgt_sr_we,
  output logic [SIZE_TGT_AR-1:0] ow_tgt_ar,
  output logic                   ow_tgt_ar_we,
  output logic [DATA_W-1:0]      ow_result,
  output logic [ADDR_W-1:0]      ow_sr_result,
  output logic [ADDR_W-1:0]      ow_ar_result,
  output logic                   ow_stall,
  output logic                   ow_mem_err
);

  typedef struct packed {
    logic [ADDR_W-1:0]      pc;
    logic [DATA_W-1:0]      instr;
    logic [SIZE_OPC-1:0]    opc;
    logic [SIZE_TGT_GP-1:0] tgt_gp;
    logic                   tgt_gp_we;
    logic [SIZE_TGT_SR-1:0] tgt_sr;
    logic                   tgt_sr_we;
    logic [SIZE_TGT_AR-1:0] tgt_ar;
    logic                   tgt_ar_we;
    logic [DATA_W-1:0]      result;
    logic [ADDR_W-1:0]      sr_result;
    logic [ADDR_W-1:0]      ar_result;
  } bundle_t;

  bundle_t in_b;
  bundle_t hold_q;
  bundle_t out_q, out_d;
  logic    hold_load_q;
  logic    start;
  logic    stall;
  logic    done;
  logic    expire;

  assign in_b = '{
    pc:        iw_pc,
    instr:     iw_instr,
    opc:       iw_opc,
    tgt_gp:    iw_tgt_gp,
    tgt_gp_we: iw_tgt_gp_we,
    tgt_sr:    iw_tgt_sr,
    tgt_sr_we: iw_tgt_sr_we,
    tgt_ar:    iw_tgt_ar,
    tgt_ar_we: iw_tgt_ar_we,
    result:    iw_result,
    sr_result: iw_sr_result,
    ar_result: iw_ar_result
  };

  assign start = is_mem_op(iw_mem_rd, iw_mem_wr);

  stg_ma_memif #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_memif (
    .iw_clk      (iw_clk),
    .iw_rst      (iw_rst),
    .start       (start),
    .start_we    (iw_mem_wr),
    .start_addr  (iw_mem_addr),
    .start_wdata (iw_mem_wdata),
    .ack         (mem.ack),
    .req         (mem.req),
    .we          (mem.we),
    .addr        (mem.addr),
    .wdata       (mem.wdata),
    .stall       (stall),
    .done        (done),
    .expire      (expire),
    .err         (ow_mem_err)
  );

  // Capture the bundle when an access is issued; only a pure load takes rdata.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      hold_q      <= '0;
      hold_load_q <= 1'b0;
    end else if (!stall && start) begin
      hold_q      <= in_b;
      hold_load_q <= iw_mem_rd & ~iw_mem_wr;
    end
  end

  // Writeback mux: pass-through when idle, held bundle on ack, bubble otherwise.
  always_comb begin
    out_d = '0;
    if (!stall) begin
      if (!start) out_d = in_b;
    end else if (done) begin
      out_d = hold_q;
      if (hold_load_q) out_d.result = mem.rdata;
    end
  end

  // Output register to writeback.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) out_q <= '0;
    else        out_q <= out_d;
  end

  assign ow_pc        = out_q.pc;
  assign ow_instr     = out_q.instr;
  assign ow_opc       = out_q.opc;
  assign ow_tgt_gp    = out_q.tgt_gp;
  assign ow_tgt_gp_we = out_q.tgt_gp_we;
  assign ow_tgt_sr    = out_q.tgt_sr;
  assign ow_tgt_sr_we = out_q.tgt_sr_we;
  assign ow_tgt_ar    = out_q.tgt_ar;
  assign ow_tgt_ar_we = out_q.tgt_ar_we;
  assign ow_result    = out_q.result;
  assign ow_sr_result = out_q.sr_result;
  assign ow_ar_result = out_q.ar_result;
  assign ow_stall     = stall;

endmodule

// File: tb/tb_stg_ma.sv
// Directed bench for stg_ma; the timeout section follows AMBER_MA_TIMEOUT_EN.
module tb_stg_ma;
  import stg_ma_pkg::*;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 48;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [AW-1:0]          iw_pc;
  logic [DW-1:0]          iw_instr;
  logic [SIZE_OPC-1:0]    iw_opc;
  logic [SIZE_TGT_GP-1:0] iw_tgt_gp;
  logic                   iw_tgt_gp_we;
  logic [SIZE_TGT_SR-1:0] iw_tgt_sr;
  logic                   iw_tgt_sr_we;
  logic [SIZE_TGT_AR-1:0] iw_tgt_ar;
  logic                   iw_tgt_ar_we;
  logic [DW-1:0]          iw_result;
  logic [AW-1:0]          iw_sr_result;
  logic [AW-1:0]          iw_ar_result;
  logic                   iw_mem_rd;
  logic                   iw_mem_wr;
  logic [AW-1:0]          iw_mem_addr;
  logic [DW-1:0]          iw_mem_wdata;
  logic [AW-1:0]          ow_pc;
  logic [DW-1:0]          ow_instr;
  logic [SIZE_OPC-1:0]    ow_opc;
  logic [SIZE_TGT_GP-1:0] ow_tgt_gp;
  logic                   ow_tgt_gp_we;
  logic [SIZE_TGT_SR-1:0] ow_tgt_sr;
  logic                   ow_tgt_sr_we;
  logic [SIZE_TGT_AR-1:0] ow_tgt_ar;
  logic                   ow_tgt_ar_we;
  logic [DW-1:0]          ow_result;
  logic [AW-1:0]          ow_sr_result;
  logic [AW-1:0]          ow_ar_result;
  logic                   ow_stall;
  logic                   ow_mem_err;

  int total = 0;
  int bad   = 0;

  stg_ma_if #(.DATA_W(DW), .ADDR_W(AW)) mem_bus ();

  stg_ma #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (4)
  ) dut (
    .iw_clk       (clk),
    .iw_rst       (rst),
    .iw_pc        (iw_pc),
    .iw_instr     (iw_instr),
    .iw_opc       (iw_opc),
    .iw_tgt_gp    (iw_tgt_gp),
    .iw_tgt_gp_we (iw_tgt_gp_we),
    .iw_tgt_sr    (iw_tgt_sr),
    .iw_tgt_sr_we (iw_tgt_sr_we),
    .iw_tgt_ar    (iw_tgt_ar),
    .iw_tgt_ar_we (iw_tgt_ar_we),
    .iw_result    (iw_result),
    .iw_sr_result (iw_sr_result),
    .iw_ar_result (iw_ar_result),
    .iw_mem_rd    (iw_mem_rd),
    .iw_mem_wr    (iw_mem_wr),
    .iw_mem_addr  (iw_mem_addr),
    .iw_mem_wdata (iw_mem_wdata),
    .mem          (mem_bus),
    .ow_pc        (ow_pc),
    .ow_instr     (ow_instr),
    .ow_opc       (ow_opc),
    .ow_tgt_gp    (ow_tgt_gp),
    .ow_tgt_gp_we (ow_tgt_gp_we),
    .ow_tgt_sr    (ow_tgt_sr),
    .ow_tgt_sr_we (ow_tgt_sr_we),
    .ow_tgt_ar    (ow_tgt_ar),
    .ow_tgt_ar_we (ow_tgt_ar_we),
    .ow_result    (ow_result),
    .ow_sr_result (ow_sr_result),
    .ow_ar_result (ow_ar_result),
    .ow_stall     (ow_stall),
    .ow_mem_err   (ow_mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    iw_pc = '0; iw_instr = '0; iw_opc = '0;
    iw_tgt_gp = '0; iw_tgt_gp_we = 1'b0;
    iw_tgt_sr = '0; iw_tgt_sr_we = 1'b0;
    iw_tgt_ar = '0; iw_tgt_ar_we = 1'b0;
    iw_result = '0; iw_sr_result = '0; iw_ar_result = '0;
    iw_mem_rd = 1'b0; iw_mem_wr = 1'b0; iw_mem_addr = '0; iw_mem_wdata = '0;
    mem_bus.ack = 1'b0; mem_bus.rdata = '0;
  endtask

  task automatic set_op(input logic [AW-1:0] pc, input logic [DW-1:0] instr,
                        input logic [DW-1:0] res, input logic [SIZE_TGT_GP-1:0] gp,
                        input logic gp_we);
    clr_in();
    iw_pc = pc; iw_instr = instr; iw_opc = 8'h01;
    iw_result = res; iw_tgt_gp = gp; iw_tgt_gp_we = gp_we;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    #2;
    chk("rst_req", 64'(mem_bus.req), 64'd0);
    chk("rst_stall", 64'(ow_stall), 64'd0);
    chk("rst_err", 64'(ow_mem_err), 64'd0);
    chk("rst_gp_we", 64'(ow_tgt_gp_we), 64'd0);
    chk("rst_result", 64'(ow_result), 64'd0);
    tick();
    rst = 1'b0;

    // ALU op passes with one cycle latency.
    set_op(48'h10, 24'h111111, 24'h00ABCD, 4'd3, 1'b1);
    tick();
    chk("alu_result", 64'(ow_result), 64'h00ABCD);
    chk("alu_gp_we", 64'(ow_tgt_gp_we), 64'd1);
    chk("alu_gp", 64'(ow_tgt_gp), 64'd3);
    chk("alu_pc", 64'(ow_pc), 64'h10);
    chk("alu_stall", 64'(ow_stall), 64'd0);
    chk("alu_req", 64'(mem_bus.req), 64'd0);

    // Ack while idle is ignored.
    set_op(48'h14, 24'h101010, 24'h000042, 4'd2, 1'b1);
    mem_bus.ack = 1'b1; mem_bus.rdata = 24'h777777;
    tick();
    chk("idle_ack_req", 64'(mem_bus.req), 64'd0);
    chk("idle_ack_result", 64'(ow_result), 64'h42);

    // Load, ack in the third request cycle, followed by an ALU op held upstream.
    set_op(48'h20, 24'h222222, 24'h000777, 4'd5, 1'b1);
    iw_mem_rd = 1'b1; iw_mem_addr = 48'h200;
    tick();
    chk("ld_req1", 64'(mem_bus.req), 64'd1);
    chk("ld_we", 64'(mem_bus.we), 64'd0);
    chk("ld_addr", 64'(mem_bus.addr), 64'h200);
    chk("ld_stall1", 64'(ow_stall), 64'd1);
    chk("ld_bubble_we", 64'(ow_tgt_gp_we), 64'd0);
    chk("ld_bubble_instr", 64'(ow_instr), 64'd0);
    set_op(48'h24, 24'h333333, 24'h0000AA, 4'd6, 1'b1);
    tick();
    chk("ld_req2", 64'(mem_bus.req), 64'd1);
    chk("ld_stall2", 64'(ow_stall), 64'd1);
    chk("ld_bubble2_we", 64'(ow_tgt_gp_we), 64'd0);
    tick();
    chk("ld_req3", 64'(mem_bus.req), 64'd1);
    chk("ld_addr3", 64'(mem_bus.addr), 64'h200);
    mem_bus.ack = 1'b1; mem_bus.rdata = 24'h123456;
    tick();
    mem_bus.ack = 1'b0; mem_bus.rdata = '0;
    chk("ld_req_drop", 64'(mem_bus.req), 64'd0);
    chk("ld_stall_drop", 64'(ow_stall), 64'd0);
    chk("ld_result", 64'(ow_result), 64'h123456);
    chk("ld_gp_we", 64'(ow_tgt_gp_we), 64'd1);
    chk("ld_pc", 64'(ow_pc), 64'h20);
    chk("ld_gp", 64'(ow_tgt_gp), 64'd5);
    tick();
    chk("b2b_alu_pc", 64'(ow_pc), 64'h24);
    chk("b2b_alu_result", 64'(ow_result), 64'hAA);
    clr_in();
    tick();
    chk("b2b_no_dup", 64'(ow_tgt_gp_we), 64'd0);

    // Store with ack in the first request cycle; rdata must not be used.
    clr_in();
    iw_pc = 48'h30; iw_instr = 24'h444444; iw_result = 24'h0000CC;
    iw_tgt_sr = 2'd1; iw_tgt_sr_we = 1'b1; iw_sr_result = 48'h5A;
    iw_mem_wr = 1'b1; iw_mem_addr = 48'h300; iw_mem_wdata = 24'h00BEEF;
    tick();
    chk("st_req", 64'(mem_bus.req), 64'd1);
    chk("st_we", 64'(mem_bus.we), 64'd1);
    chk("st_addr", 64'(mem_bus.addr), 64'h300);
    chk("st_wdata", 64'(mem_bus.wdata), 64'h00BEEF);
    chk("st_stall", 64'(ow_stall), 64'd1);
    clr_in();
    mem_bus.ack = 1'b1; mem_bus.rdata = 24'h999999;
    tick();
    mem_bus.ack = 1'b0;
    chk("st_req_drop", 64'(mem_bus.req), 64'd0);
    chk("st_stall_drop", 64'(ow_stall), 64'd0);
    chk("st_result", 64'(ow_result), 64'hCC);
    chk("st_sr_we", 64'(ow_tgt_sr_we), 64'd1);
    chk("st_sr_result", 64'(ow_sr_result), 64'h5A);
    chk("st_pc", 64'(ow_pc), 64'h30);

    // Both rd and wr set: behaves as a store.
    set_op(48'h40, 24'h555555, 24'h0000DD, 4'd7, 1'b1);
    iw_mem_rd = 1'b1; iw_mem_wr = 1'b1; iw_mem_addr = 48'h400;
    tick();
    chk("rw_we", 64'(mem_bus.we), 64'd1);
    clr_in();
    mem_bus.ack = 1'b1; mem_bus.rdata = 24'h444444;
    tick();
    mem_bus.ack = 1'b0;
    chk("rw_result", 64'(ow_result), 64'hDD);

    // Reset during the second wait cycle abandons the access.
    set_op(48'h50, 24'h666666, 24'h000001, 4'd1, 1'b1);
    iw_mem_rd = 1'b1; iw_mem_addr = 48'h500;
    tick();
    clr_in();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_req", 64'(mem_bus.req), 64'd0);
    chk("mrst_stall", 64'(ow_stall), 64'd0);
    chk("mrst_addr", 64'(mem_bus.addr), 64'd0);
    chk("mrst_gp_we", 64'(ow_tgt_gp_we), 64'd0);
    tick();
    rst = 1'b0;
    set_op(48'h60, 24'h777777, 24'h000ABC, 4'd9, 1'b1);
    tick();
    chk("post_rst_result", 64'(ow_result), 64'hABC);
    chk("post_rst_pc", 64'(ow_pc), 64'h60);

`ifdef AMBER_MA_TIMEOUT_EN
    // No ack: four request cycles, then abort with a one-cycle error pulse.
    set_op(48'h70, 24'h888888, 24'h000002, 4'd4, 1'b1);
    iw_mem_rd = 1'b1; iw_mem_addr = 48'h700;
    tick();
    clr_in();
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req_hold", 64'(mem_bus.req), 64'd1);
      chk("tmo_no_err", 64'(ow_mem_err), 64'd0);
      tick();
    end
    chk("tmo_err", 64'(ow_mem_err), 64'd1);
    chk("tmo_req_drop", 64'(mem_bus.req), 64'd0);
    chk("tmo_stall_drop", 64'(ow_stall), 64'd0);
    chk("tmo_bubble", 64'(ow_tgt_gp_we), 64'd0);
    tick();
    chk("tmo_err_pulse", 64'(ow_mem_err), 64'd0);

    // Ack in the expiry cycle wins.
    set_op(48'h80, 24'h999999, 24'h000003, 4'd8, 1'b1);
    iw_mem_rd = 1'b1; iw_mem_addr = 48'h800;
    tick();
    clr_in();
    tick(); tick(); tick();
    mem_bus.ack = 1'b1; mem_bus.rdata = 24'h0F0F0F;
    tick();
    mem_bus.ack = 1'b0;
    chk("tmo_ack_result", 64'(ow_result), 64'h0F0F0F);
    chk("tmo_ack_gp_we", 64'(ow_tgt_gp_we), 64'd1);
    tick();
    chk("tmo_ack_no_err", 64'(ow_mem_err), 64'd0);
`else
    // Without the timeout the wait is indefinite and no error is raised.
    set_op(48'h70, 24'h888888, 24'h000002, 4'd4, 1'b1);
    iw_mem_rd = 1'b1; iw_mem_addr = 48'h700;
    tick();
    clr_in();
    for (int i = 0; i < 10; i++) tick();
    chk("wait_req_hold", 64'(mem_bus.req), 64'd1);
    chk("wait_stall_hold", 64'(ow_stall), 64'd1);
    chk("wait_no_err", 64'(ow_mem_err), 64'd0);
    mem_bus.ack = 1'b1; mem_bus.rdata = 24'h0F0F0F;
    tick();
    mem_bus.ack = 1'b0;
    chk("wait_result", 64'(ow_result), 64'h0F0F0F);
    chk("wait_err_after", 64'(ow_mem_err), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
